// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the riscv_lsu load/store unit:
// access-size encodings, the FSM state type and the store-side lane helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Byte enables for an access; unknown sizes behave as a full word.
    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane it could land in.
    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            LDST_B, LDST_BU: d = {4{wd[7:0]}};
            LDST_H, LDST_HU: d = {2{wd[15:0]}};
            default:         d = wd;
        endcase
        return d;
    endfunction

    // True when the offset cannot be served by a single naturally aligned lane.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic m;
        case (size)
            LDST_B, LDST_BU: m = 1'b0;
            LDST_H, LDST_HU: m = off[0];
            default:         m = (off != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/riscv_lsu_lane_ext.sv
// Read-side lane select and sign/zero extension for the load/store unit.
// Pure combinational: word + size + byte offset -> right-aligned result.
module lsu_lane_ext
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half-word out of the bus word.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane; sizes without a narrow meaning pass the word.
    always_comb begin
        o_result = i_word;
        case (i_size)
            LDST_B:  o_result = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_result = {24'd0, w_byte};
            LDST_H:  o_result = {{16{w_half[15]}}, w_half};
            LDST_HU: o_result = {16'd0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and a ready-handshake memory bus.
// Each core access becomes one word-aligned bus request; the core is stalled
// until the access reaches DONE.
// Optional build macro LSU_MISALIGN_CHECK_EN adds lsu_misalign_o and aborts
// misaligned H/HU/W accesses without touching the bus.
//
// Bus handshake: mem_req_o is held high with stable we/be/addr/wd for every
// BUSY cycle; the access completes on the first rising edge where
// mem_req_o and mem_ready_i are both 1, and mem_rd_i is sampled on that edge.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        lsu_err_o
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic        lsu_misalign_o
`endif
);

    lsu_state_t  r_state;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic [31:0] r_wait_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wd;
    logic        r_err;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        r_misalign;
`endif

    logic [31:0] w_cnt_next;
    logic        w_timeout;
    logic        w_misalign;
    logic [31:0] w_rd;

    assign w_cnt_next = r_wait_cnt + 32'd1;
    // The current BUSY cycle is the last one allowed; ready still takes priority.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = lsu_misaligned(core_size_i, core_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Access FSM: latch the request, run the bus handshake, present the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_size     <= 3'd0;
            r_off      <= 2'd0;
            r_rdata    <= 32'd0;
            r_wait_cnt <= 32'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 4'd0;
            r_mem_addr <= 32'd0;
            r_mem_wd   <= 32'd0;
            r_err      <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (core_req_i) begin
                        r_size     <= core_size_i;
                        r_off      <= core_addr_i[1:0];
                        r_mem_addr <= {core_addr_i[31:2], 2'b00};
                        r_mem_be   <= lsu_be(core_size_i, core_addr_i[1:0]);
                        r_mem_wd   <= lsu_wdata(core_size_i, core_wd_i);
                        r_wait_cnt <= 32'd0;
                        if (w_misalign) begin
                            r_rdata <= 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
                            r_misalign <= 1'b1;
`endif
                            r_state <= DONE;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_mem_we  <= core_we_i;
                            r_state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_wait_cnt <= w_cnt_next;
                    if (mem_ready_i) begin
                        r_rdata   <= mem_rd_i;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= DONE;
                    end else if (w_timeout) begin
                        r_rdata   <= 32'd0;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    lsu_lane_ext u_lane_ext (
        .i_word   (r_rdata),
        .i_size   (r_size),
        .i_offset (r_off),
        .o_result (w_rd)
    );

    assign core_stall_o = core_req_i & (r_state != DONE);
    assign core_rd_o    = w_rd;
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_be_o     = r_mem_be;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wd_o     = r_mem_wd;
    assign lsu_err_o    = r_err;
`ifdef LSU_MISALIGN_CHECK_EN
    assign lsu_misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Testbench for riscv_lsu: table of directed accesses plus hand-written
// sequences for timeout, reset during BUSY and (when LSU_MISALIGN_CHECK_EN
// is defined) misaligned aborts. u_dut has the timeout disabled, u_dut_to
// uses TIMEOUT_CYCLES = 4.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared core/bus stimulus ----------------
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] mem_rd;

    // u_dut (no timeout)
    logic        core_req;
    logic        mem_ready;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        lsu_err;

    // u_dut_to (TIMEOUT_CYCLES = 4)
    logic        core_req_t;
    logic        mem_ready_t;
    logic [31:0] core_rd_t;
    logic        core_stall_t;
    logic        mem_req_t;
    logic        mem_we_t;
    logic [3:0]  mem_be_t;
    logic [31:0] mem_addr_t;
    logic [31:0] mem_wd_t;
    logic        lsu_err_t;

`ifdef LSU_MISALIGN_CHECK_EN
    logic        lsu_misalign;
    logic        lsu_misalign_t;
`endif

    riscv_lsu u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready),
        .lsu_err_o    (lsu_err)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .lsu_misalign_o (lsu_misalign)
`endif
    );

    riscv_lsu #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req_t),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd_t),
        .core_stall_o (core_stall_t),
        .mem_req_o    (mem_req_t),
        .mem_we_o     (mem_we_t),
        .mem_be_o     (mem_be_t),
        .mem_addr_o   (mem_addr_t),
        .mem_wd_o     (mem_wd_t),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready_t),
        .lsu_err_o    (lsu_err_t)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .lsu_misalign_o (lsu_misalign_t)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;
        logic        chk_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    // ---------------- driver task ----------------
    // Runs one access on the selected DUT. delay < 0 means ready is never given.
    task automatic run_access(
        input  bit          sel,
        input  logic        we,
        input  logic [2:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rdata,
        input  int          delay,
        output int          n_req,
        output int          n_stall,
        output int          n_err,
        output logic [3:0]  be_o,
        output logic [31:0] addr_o,
        output logic [31:0] wd_o,
        output logic        we_o,
        output logic [31:0] rd_o,
        output logic [31:0] rd_hold,
        output bit          done
    );
        logic o_req;
        n_req = 0; n_stall = 0; n_err = 0; done = 0;
        be_o = 4'd0; addr_o = 32'd0; wd_o = 32'd0; we_o = 1'b0;
        rd_o = 32'd0; rd_hold = 32'd0;
        @(negedge clk);
        core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        if (sel) core_req_t = 1'b1; else core_req = 1'b1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            o_req = sel ? mem_req_t : mem_req;
            mem_ready = 1'b0; mem_ready_t = 1'b0; mem_rd = 32'hDEADBEEF;
            if (o_req) begin
                n_req++;
                if (n_req == 1) begin
                    be_o   = sel ? mem_be_t   : mem_be;
                    addr_o = sel ? mem_addr_t : mem_addr;
                    wd_o   = sel ? mem_wd_t   : mem_wd;
                    we_o   = sel ? mem_we_t   : mem_we;
                end
                if (delay >= 0 && n_req == delay + 1) begin
                    mem_rd = rdata;
                    if (sel) mem_ready_t = 1'b1; else mem_ready = 1'b1;
                end
            end
            #1;
            if (sel ? lsu_err_t : lsu_err) n_err++;
            if (sel ? core_stall_t : core_stall) n_stall++;
            else begin
                done = 1;
                rd_o = sel ? core_rd_t : core_rd;
            end
        end
        @(negedge clk);
        core_req = 1'b0; core_req_t = 1'b0; mem_ready = 1'b0; mem_ready_t = 1'b0;
        mem_rd = 32'h5A5A5A5A;
        #1;
        if (sel ? lsu_err_t : lsu_err) n_err++;
        rd_hold = sel ? core_rd_t : core_rd;
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int          n_req, n_stall, n_err;
        logic [3:0]  be_o;
        logic [31:0] addr_o, wd_o, rd_o, rd_hold;
        logic        we_o;
        bit          done;

        vecs[0]  = '{1'b1, LDST_B,  32'h0000_0103, 32'h0000_00AB, 32'h0000_0000, 0, 1'b0, 4'b1000, 32'h0000_0100, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{1'b0, LDST_B,  32'h0000_0202, 32'h1234_5678, 32'h80FF_7F01, 0, 1'b1, 4'b0100, 32'h0000_0200, 32'h7878_7878, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, LDST_BU, 32'h0000_0203, 32'h1234_5678, 32'h80FF_7F01, 0, 1'b1, 4'b1000, 32'h0000_0200, 32'h7878_7878, 32'h0000_0080};
        vecs[3]  = '{1'b0, LDST_H,  32'h0000_0200, 32'h1234_5678, 32'h80FF_7F01, 0, 1'b1, 4'b0011, 32'h0000_0200, 32'h5678_5678, 32'h0000_7F01};
        vecs[4]  = '{1'b0, LDST_HU, 32'h0000_0302, 32'h1234_5678, 32'h80FF_7F01, 1, 1'b1, 4'b1100, 32'h0000_0300, 32'h5678_5678, 32'h0000_80FF};
        vecs[5]  = '{1'b0, LDST_H,  32'h0000_0302, 32'h1234_5678, 32'h80FF_7F01, 0, 1'b1, 4'b1100, 32'h0000_0300, 32'h5678_5678, 32'hFFFF_80FF};
        vecs[6]  = '{1'b0, LDST_W,  32'h0000_0404, 32'h1234_5678, 32'hCAFE_F00D, 5, 1'b1, 4'b1111, 32'h0000_0404, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, LDST_H,  32'h0000_0506, 32'h0000_BEEF, 32'h0000_0000, 0, 1'b0, 4'b1100, 32'h0000_0504, 32'hBEEF_BEEF, 32'h0};
        vecs[8]  = '{1'b1, LDST_W,  32'h0000_0508, 32'h89AB_CDEF, 32'h0000_0000, 2, 1'b0, 4'b1111, 32'h0000_0508, 32'h89AB_CDEF, 32'h0};
        vecs[9]  = '{1'b0, LDST_B,  32'h0000_0601, 32'h1234_5678, 32'h0000_8000, 0, 1'b1, 4'b0010, 32'h0000_0600, 32'h7878_7878, 32'hFFFF_FF80};
        vecs[10] = '{1'b0, 3'd3,    32'h0000_0700, 32'h1234_5678, 32'h1357_9BDF, 0, 1'b1, 4'b1111, 32'h0000_0700, 32'h1234_5678, 32'h1357_9BDF};
        vecs[11] = '{1'b1, 3'd7,    32'h0000_0704, 32'h0F0F_0F0F, 32'h0000_0000, 0, 1'b0, 4'b1111, 32'h0000_0704, 32'h0F0F_0F0F, 32'h0};
        vecs[12] = '{1'b0, LDST_BU, 32'h0000_0800, 32'h1234_5678, 32'h0000_00FE, 3, 1'b1, 4'b0001, 32'h0000_0800, 32'h7878_7878, 32'h0000_00FE};

        // Reset state
        rst_n = 1'b0;
        core_req = 1'b0; core_req_t = 1'b0; core_we = 1'b0; core_size = 3'd0;
        core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0;
        mem_ready = 1'b0; mem_ready_t = 1'b0;
        repeat (2) @(negedge clk);
        check32("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check32("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        check32("rst_mem_be",   {28'd0, mem_be}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_wd",   mem_wd, 32'd0);
        check32("rst_err",      {31'd0, lsu_err}, 32'd0);
        check32("rst_core_rd",  core_rd, 32'd0);
        check32("rst_stall",    {31'd0, core_stall}, 32'd0);
        rst_n = 1'b1;

        // Table-driven accesses on the no-timeout instance
        for (int i = 0; i < NVEC; i++) begin
            run_access(1'b0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].rdata,
                       vecs[i].delay, n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o,
                       rd_o, rd_hold, done);
            check32($sformatf("v%0d_done", i),  {31'd0, done}, 32'd1);
            check32($sformatf("v%0d_be", i),    {28'd0, be_o}, {28'd0, vecs[i].exp_be});
            check32($sformatf("v%0d_addr", i),  addr_o, vecs[i].exp_addr);
            check32($sformatf("v%0d_wd", i),    wd_o, vecs[i].exp_wd);
            check32($sformatf("v%0d_we", i),    {31'd0, we_o}, {31'd0, vecs[i].we});
            check32($sformatf("v%0d_req_cyc", i),   n_req, vecs[i].delay + 1);
            check32($sformatf("v%0d_stall_cyc", i), n_stall, vecs[i].delay + 2);
            check32($sformatf("v%0d_err", i),   n_err, 0);
            if (vecs[i].chk_rd) begin
                check32($sformatf("v%0d_rd", i),      rd_o, vecs[i].exp_rd);
                check32($sformatf("v%0d_rd_hold", i), rd_hold, vecs[i].exp_rd);
            end
        end

        // Timeout: ready never comes, aborted after 4 BUSY cycles
        run_access(1'b1, 1'b0, LDST_W, 32'h0000_0A00, 32'h0, 32'h1111_1111, -1,
                   n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o, rd_o, rd_hold, done);
        check32("to_done",      {31'd0, done}, 32'd1);
        check32("to_req_cyc",   n_req, 4);
        check32("to_stall_cyc", n_stall, 5);
        check32("to_err_pulse", n_err, 1);
        check32("to_rd_zero",   rd_o, 32'd0);

        // Ready arrives in the same cycle the timeout would fire: ready wins
        run_access(1'b1, 1'b0, LDST_W, 32'h0000_0A04, 32'h0, 32'h2468_ACE0, 3,
                   n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o, rd_o, rd_hold, done);
        check32("to_tie_req_cyc", n_req, 4);
        check32("to_tie_err",      n_err, 0);
        check32("to_tie_rd",       rd_o, 32'h2468_ACE0);

        // Reset asserted asynchronously in the middle of BUSY
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_size = LDST_W;
        core_addr = 32'h0000_0900; core_wd = 32'hFEED_FACE; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check32("rstmid_busy_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check32("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
        check32("rstmid_we_drop",  {31'd0, mem_we}, 32'd0);
        check32("rstmid_state",    {30'd0, u_dut.r_state}, {30'd0, IDLE});
        check32("rstmid_stall_hi", {31'd0, core_stall}, 32'd1);
        core_req = 1'b0;
        #1;
        check32("rstmid_stall_lo", {31'd0, core_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset: a normal halfword load
        run_access(1'b0, 1'b0, LDST_HU, 32'h0000_0B02, 32'h0, 32'hA5A5_0000, 0,
                   n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o, rd_o, rd_hold, done);
        check32("recov_rd",    rd_o, 32'h0000_A5A5);
        check32("recov_stall", n_stall, 2);

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned word load: no bus request, one-cycle misalign pulse
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h0000_0102;
        #1;
        check32("mis_idle_stall", {31'd0, core_stall}, 32'd1);
        check32("mis_idle_req",   {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        check32("mis_done_req",   {31'd0, mem_req}, 32'd0);
        check32("mis_pulse",      {31'd0, lsu_misalign}, 32'd1);
        check32("mis_done_stall", {31'd0, core_stall}, 32'd0);
        check32("mis_rd_zero",    core_rd, 32'd0);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        check32("mis_pulse_end",  {31'd0, lsu_misalign}, 32'd0);
        check32("mis_after_req",  {31'd0, mem_req}, 32'd0);

        // Misaligned halfword also aborts; byte at odd address does not
        run_access(1'b0, 1'b0, LDST_H, 32'h0000_0103, 32'h0, 32'h1234_5678, 0,
                   n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o, rd_o, rd_hold, done);
        check32("mis_h_req",   n_req, 0);
        check32("mis_h_stall", n_stall, 1);
        run_access(1'b0, 1'b0, LDST_BU, 32'h0000_0103, 32'h0, 32'h9A00_0000, 0,
                   n_req, n_stall, n_err, be_o, addr_o, wd_o, we_o, rd_o, rd_hold, done);
        check32("mis_b_req", n_req, 1);
        check32("mis_b_rd",  rd_o, 32'h0000_009A);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
